// File: rtl/record_play_sequencer.sv
// rtl/record_play_sequencer.sv - record/playback sequencer for a 64-entry note RAM
//
// Records note_in words into an external note RAM on beat_tick, then plays them
// back, once or looping, with the RAM read data presented on note_out.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   select      button level; its rising edge starts/stops record and play
//   back        button level; its rising edge aborts to IDLE
//   mode_sel    1 = record, 0 = play (sampled on select rise in IDLE)
//   loop_en     1 = wrap playback to address 0 after the last note
//   beat_tick   one-cycle tempo pulse
//   note_in     note word to record
//   ram_q       note RAM read data (one-cycle read latency)
//   ram_addr    note RAM address (0 outside RECORDING/PLAYING)
//   ram_wren    note RAM write enable
//   ram_data    note RAM write data
//   note_out    last note read during playback
//   note_valid  one-cycle pulse when note_out is updated
//   length      number of recorded notes, 0..64
//   state       IDLE=0, REC_ARM=1, RECORDING=2, PLAYING=3
module record_play_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic        back,
  input  logic        mode_sel,
  input  logic        loop_en,
  input  logic        beat_tick,
  input  logic [31:0] note_in,
  input  logic [31:0] ram_q,
  output logic [5:0]  ram_addr,
  output logic        ram_wren,
  output logic [31:0] ram_data,
  output logic [31:0] note_out,
  output logic        note_valid,
  output logic [6:0]  length,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REC_ARM   = 2'd1,
    RECORDING = 2'd2,
    PLAYING   = 2'd3
  } state_t;

  state_t     st;
  logic       select_q;
  logic       back_q;
  logic [5:0] addr;
  logic       rd_pend;   // a read was issued last cycle; ram_q is valid now
  logic       stop;      // final non-looping read issued; leave after its pulse
  logic       sel_rise;
  logic       back_rise;
  logic       last_read;

  assign sel_rise  = select & ~select_q;
  assign back_rise = back & ~back_q;
  assign last_read = ({1'b0, addr} == (length - 7'd1));

  assign state    = st;
  // Write is issued in the tick cycle itself; a reset in that cycle cancels it.
  assign ram_wren = (st == RECORDING) && beat_tick && !reset;
  assign ram_data = note_in;
  assign ram_addr = ((st == RECORDING) || (st == PLAYING)) ? addr : 6'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      select_q   <= 1'b0;
      back_q     <= 1'b0;
      addr       <= 6'd0;
      length     <= 7'd0;
      note_out   <= 32'd0;
      note_valid <= 1'b0;
      rd_pend    <= 1'b0;
      stop       <= 1'b0;
    end else begin
      select_q   <= select;
      back_q     <= back;
      note_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (sel_rise) begin
            if (mode_sel) begin
              st <= REC_ARM;
            end else if (length != 7'd0) begin
              st      <= PLAYING;
              addr    <= 6'd0;
              rd_pend <= 1'b0;
              stop    <= 1'b0;
            end
          end
        end
        REC_ARM: begin
          if (back_rise) begin
            st <= IDLE;
          end else if (sel_rise) begin
            st     <= RECORDING;
            addr   <= 6'd0;
            length <= 7'd0;
          end
        end
        RECORDING: begin
          if (beat_tick) begin
            addr   <= addr + 6'd1;
            length <= length + 7'd1;
          end
          // The 64th write also ends recording; addr is parked at 0 so it never wraps into use.
          if (sel_rise || back_rise || (beat_tick && (length == 7'd63))) begin
            st   <= IDLE;
            addr <= 6'd0;
          end
        end
        PLAYING: begin
          if (sel_rise || back_rise) begin
            st       <= IDLE;
            addr     <= 6'd0;
            note_out <= 32'd0;
            rd_pend  <= 1'b0;
            stop     <= 1'b0;
          end else begin
            rd_pend <= 1'b0;
            if (rd_pend) begin
              note_out   <= ram_q;
              note_valid <= 1'b1;
            end
            if (beat_tick && !stop) begin
              rd_pend <= 1'b1;
              if (last_read) begin
                if (loop_en) addr <= 6'd0;
                else         stop <= 1'b1;
              end else begin
                addr <= addr + 6'd1;
              end
            end
            // Exit only once the final read's pulse has gone out and nothing is in flight.
            if (stop && note_valid && !rd_pend) begin
              st   <= IDLE;
              addr <= 6'd0;
              stop <= 1'b0;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_record_play_sequencer.sv
// tb/tb_record_play_sequencer.sv - self-checking bench for record_play_sequencer
module tb_record_play_sequencer;

  logic        clk = 1'b0;
  logic        reset, select, back, mode_sel, loop_en, beat_tick;
  logic [31:0] note_in;
  logic [31:0] ram_q = 32'd0;
  logic [5:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_data;
  logic [31:0] note_out;
  logic        note_valid;
  logic [6:0]  length;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [64];
  int          wr_cnt = 0;
  logic [5:0]  last_wr_addr = 6'd0;
  logic [5:0]  rd_log [64];
  int          rd_cnt = 0;

  record_play_sequencer dut (
    .clk(clk), .reset(reset), .select(select), .back(back),
    .mode_sel(mode_sel), .loop_en(loop_en), .beat_tick(beat_tick),
    .note_in(note_in), .ram_q(ram_q), .ram_addr(ram_addr),
    .ram_wren(ram_wren), .ram_data(ram_data), .note_out(note_out),
    .note_valid(note_valid), .length(length), .state(state)
  );

  always #10 clk = ~clk;

  // Note RAM model with registered read, plus write/read-address loggers.
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr] <= ram_data;
      wr_cnt        <= wr_cnt + 1;
      last_wr_addr  <= ram_addr;
    end
    ram_q <= mem[ram_addr];
    if (state == 2'd3 && beat_tick) begin
      rd_log[rd_cnt[5:0]] <= ram_addr;
      rd_cnt              <= rd_cnt + 1;
    end
  end

  typedef struct {
    logic        sel, bk, mode, tick;
    logic [31:0] note;
    logic        wren;
    logic [5:0]  addr;
    logic [1:0]  st;
    logic [6:0]  len;
  } vec_t;

  vec_t vec [16];

  function automatic vec_t mk(logic sel, logic bk, logic mode, logic tick, logic [31:0] note,
                              logic wren, logic [5:0] addr, logic [1:0] st, logic [6:0] len);
    vec_t v;
    v.sel = sel; v.bk = bk; v.mode = mode; v.tick = tick; v.note = note;
    v.wren = wren; v.addr = addr; v.st = st; v.len = len;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_sel();
    select = 1'b1; step();
    select = 1'b0; step();
  endtask

  // Tick now; note_out is captured one cycle after the read, then the pulse drops.
  task automatic tick_and_check(input logic [31:0] exp_note, input logic [1:0] exp_st);
    beat_tick = 1'b1; step();
    beat_tick = 1'b0;
    chk("nv_early", {31'd0, note_valid}, 32'd1 - 32'd1);
    step();
    chk("nv_pulse", {31'd0, note_valid}, 32'd1);
    chk("note_out", note_out, exp_note);
    step();
    chk("nv_drop", {31'd0, note_valid}, 32'd0);
    chk("play_state", {30'd0, state}, {30'd0, exp_st});
  endtask

  initial begin
    int base;
    reset = 1'b1; select = 1'b0; back = 1'b0; mode_sel = 1'b0;
    loop_en = 1'b0; beat_tick = 1'b0; note_in = 32'd0;
    step(); step();
    reset = 1'b0;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_length", {25'd0, length}, 32'd0);
    chk("rst_nv", {31'd0, note_valid}, 32'd0);
    chk("rst_note_out", note_out, 32'd0);
    chk("rst_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_addr", {26'd0, ram_addr}, 32'd0);

    //           sel bk mode tick note          wren addr st len
    vec[0]  = mk(1, 0, 0, 0, 32'h0,          0, 0, 0, 0);  // play with length 0 stays IDLE
    vec[1]  = mk(0, 0, 1, 0, 32'h0,          0, 0, 0, 0);
    vec[2]  = mk(1, 0, 1, 0, 32'h0,          0, 0, 1, 0);
    vec[3]  = mk(0, 0, 1, 0, 32'h0,          0, 0, 1, 0);
    vec[4]  = mk(1, 0, 1, 0, 32'h0,          0, 0, 2, 0);
    vec[5]  = mk(0, 0, 1, 0, 32'h0,          0, 0, 2, 0);
    vec[6]  = mk(0, 0, 1, 1, 32'h1,          1, 0, 2, 1);
    vec[7]  = mk(0, 0, 1, 0, 32'hdead,       0, 1, 2, 1);
    vec[8]  = mk(0, 0, 1, 1, 32'h40,         1, 1, 2, 2);
    vec[9]  = mk(0, 0, 1, 1, 32'h1000,       1, 2, 2, 3);
    vec[10] = mk(1, 0, 1, 0, 32'h0,          0, 3, 0, 3);
    vec[11] = mk(0, 0, 1, 1, 32'h5,          0, 0, 0, 3);  // tick ignored in IDLE
    vec[12] = mk(1, 0, 1, 0, 32'h0,          0, 0, 1, 3);
    vec[13] = mk(0, 0, 1, 0, 32'h0,          0, 0, 1, 3);
    vec[14] = mk(1, 1, 1, 0, 32'h0,          0, 0, 0, 3);  // back wins over select
    vec[15] = mk(0, 0, 1, 1, 32'h7,          0, 0, 0, 3);

    for (int i = 0; i < 16; i++) begin
      select = vec[i].sel; back = vec[i].bk; mode_sel = vec[i].mode;
      beat_tick = vec[i].tick; note_in = vec[i].note;
      #2;
      chk($sformatf("v%0d_wren", i), {31'd0, ram_wren}, {31'd0, vec[i].wren});
      chk($sformatf("v%0d_addr", i), {26'd0, ram_addr}, {26'd0, vec[i].addr});
      if (vec[i].wren) chk($sformatf("v%0d_data", i), ram_data, vec[i].note);
      @(posedge clk); #1;
      chk($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, vec[i].st});
      chk($sformatf("v%0d_len", i), {25'd0, length}, {25'd0, vec[i].len});
    end
    select = 1'b0; back = 1'b0; beat_tick = 1'b0;
    step();
    chk("rec_wr_cnt", wr_cnt, 32'd3);
    chk("rec_mem0", mem[0], 32'h1);
    chk("rec_mem1", mem[1], 32'h40);
    chk("rec_mem2", mem[2], 32'h1000);

    // Play once, no loop
    mode_sel = 1'b0; loop_en = 1'b0;
    select = 1'b1; step(); select = 1'b0;
    chk("play_enter", {30'd0, state}, 32'd3);
    step();
    tick_and_check(32'h1, 2'd3);
    tick_and_check(32'h40, 2'd3);
    tick_and_check(32'h1000, 2'd0);

    // Loop playback
    loop_en = 1'b1;
    press_sel();
    base = rd_cnt;
    tick_and_check(32'h1, 2'd3);
    tick_and_check(32'h40, 2'd3);
    tick_and_check(32'h1000, 2'd3);
    tick_and_check(32'h1, 2'd3);
    tick_and_check(32'h40, 2'd3);
    chk("loop_rd0", {26'd0, rd_log[(base+0) % 64]}, 32'd0);
    chk("loop_rd1", {26'd0, rd_log[(base+1) % 64]}, 32'd1);
    chk("loop_rd2", {26'd0, rd_log[(base+2) % 64]}, 32'd2);
    chk("loop_rd3", {26'd0, rd_log[(base+3) % 64]}, 32'd0);
    chk("loop_rd4", {26'd0, rd_log[(base+4) % 64]}, 32'd1);
    back = 1'b1; step(); back = 1'b0;
    chk("abort_state", {30'd0, state}, 32'd0);
    chk("abort_note_out", note_out, 32'd0);
    chk("abort_nv", {31'd0, note_valid}, 32'd0);
    step();

    // Full memory: 70 ticks, only 64 writes
    mode_sel = 1'b1; loop_en = 1'b0;
    press_sel(); press_sel();
    chk("full_enter", {30'd0, state}, 32'd2);
    base = wr_cnt;
    for (int i = 0; i < 70; i++) begin
      note_in = i; beat_tick = 1'b1; step();
    end
    beat_tick = 1'b0;
    chk("full_writes", wr_cnt - base, 32'd64);
    chk("full_length", {25'd0, length}, 32'd64);
    chk("full_state", {30'd0, state}, 32'd0);
    chk("full_last_addr", {26'd0, last_wr_addr}, 32'd63);
    chk("full_mem0", mem[0], 32'd0);
    chk("full_mem63", mem[63], 32'd63);
    chk("idle_addr", {26'd0, ram_addr}, 32'd0);

    // Tick and select rise together in RECORDING
    press_sel(); press_sel();
    base = wr_cnt;
    select = 1'b1; beat_tick = 1'b1; note_in = 32'habc;
    #2;
    chk("sim_wren", {31'd0, ram_wren}, 32'd1);
    chk("sim_addr", {26'd0, ram_addr}, 32'd0);
    @(posedge clk); #1;
    select = 1'b0; beat_tick = 1'b0;
    chk("sim_state", {30'd0, state}, 32'd0);
    chk("sim_length", {25'd0, length}, 32'd1);
    step();
    chk("sim_writes", wr_cnt - base, 32'd1);
    chk("sim_mem0", mem[0], 32'habc);

    // Reset mid-RECORDING: no write in the reset cycle
    press_sel(); press_sel();
    note_in = 32'h77; beat_tick = 1'b1; step();
    base = wr_cnt;
    note_in = 32'h88; reset = 1'b1;
    #2;
    chk("rstrec_wren", {31'd0, ram_wren}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; beat_tick = 1'b0;
    step();
    chk("rstrec_writes", wr_cnt - base, 32'd0);
    chk("rstrec_state", {30'd0, state}, 32'd0);
    chk("rstrec_length", {25'd0, length}, 32'd0);

    // Reset mid-PLAYING with a read pending at addr 2
    press_sel(); press_sel();
    note_in = 32'h11; beat_tick = 1'b1; step(); beat_tick = 1'b0; step();
    note_in = 32'h22; beat_tick = 1'b1; step(); beat_tick = 1'b0; step();
    note_in = 32'h33; beat_tick = 1'b1; step(); beat_tick = 1'b0; step();
    press_sel();
    chk("rp_length", {25'd0, length}, 32'd3);
    mode_sel = 1'b0; loop_en = 1'b0;
    press_sel();
    tick_and_check(32'h11, 2'd3);
    tick_and_check(32'h22, 2'd3);
    beat_tick = 1'b1;
    #2;
    chk("rp_addr2", {26'd0, ram_addr}, 32'd2);
    @(posedge clk); #1;
    beat_tick = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rp_state", {30'd0, state}, 32'd0);
    chk("rp_nv", {31'd0, note_valid}, 32'd0);
    chk("rp_length0", {25'd0, length}, 32'd0);
    chk("rp_note_out", note_out, 32'd0);
    step();
    chk("rp_nv_after", {31'd0, note_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/record_play_sequencer.md
RECORD_PLAY_SEQUENCER -- requirements
Module: record_play_sequencer

Interface
REQ-001 SHALL have ports: clk input 1 system clock (50 MHz); all logic on its rising edge.
REQ-002 SHALL have ports: reset input 1; reset is synchronous and active-high.
REQ-003 SHALL have ports: select input 1 (button, active-high level); back input 1 (button, active-high level).
REQ-004 SHALL have ports: mode_sel input 1 (1 = record, 0 = play); loop_en input 1 (1 = loop playback).
REQ-005 SHALL have ports: beat_tick input 1 (one-cycle pulse from the tempo clock divider).
REQ-006 SHALL have ports: note_in input 32 (encoded string/bar word); ram_q input 32 (note RAM read data, registered, 1-cycle read latency).
REQ-007 SHALL have ports: ram_addr output 6; ram_wren output 1; ram_data output 32.
REQ-008 SHALL have ports: note_out output 32; note_valid output 1; length output 7 (recorded notes, 0..64); state output 2.

Function
REQ-009 SHALL register select and back each cycle and form sel_rise = select & ~select_q and back_rise = back & ~back_q; only rises act.
REQ-010 SHALL implement the states IDLE=0, REC_ARM=1, RECORDING=2 and PLAYING=3, and drive the state output with the current encoding.
REQ-011 IDLE: on sel_rise, if mode_sel=1 it SHALL go to REC_ARM; if mode_sel=0 and length>0 it SHALL go to PLAYING with addr=0; if mode_sel=0 and length=0 it SHALL stay in IDLE.
REQ-012 REC_ARM: back_rise SHALL return to IDLE with length unchanged; otherwise sel_rise SHALL enter RECORDING with addr=0 and length=0; back_rise SHALL win when both rise.
REQ-013 RECORDING, on beat_tick: it SHALL assert ram_wren for exactly that cycle, with ram_addr=addr and ram_data=note_in (combinational), then increment addr and length.
REQ-014 RECORDING: after the write that makes length=64, it SHALL go to IDLE; no write beyond address 63 and no address wrap are permitted.
REQ-015 RECORDING: sel_rise or back_rise SHALL go to IDLE; if beat_tick coincides, the write SHALL complete in that cycle before the exit.
REQ-016 PLAYING, on beat_tick: it SHALL present ram_addr=addr (read); one cycle later it SHALL capture ram_q into note_out and pulse note_valid for one cycle.
REQ-017 PLAYING: after a read at addr=length-1, if loop_en=1 addr SHALL wrap to 0 and playback continue; if loop_en=0 it SHALL go to IDLE after the note_valid pulse of that read.
REQ-018 PLAYING: sel_rise or back_rise SHALL go to IDLE, clear note_out to 0, and suppress any pending note_valid.
REQ-019 Outside PLAYING, note_valid SHALL be 0; outside RECORDING, ram_wren SHALL be 0.
REQ-020 In states other than RECORDING and PLAYING, ram_addr SHALL hold 0.
REQ-021 beat_tick SHALL be ignored in IDLE and REC_ARM.
REQ-022 length SHALL persist across IDLE/REC_ARM and SHALL change only in RECORDING or on reset.

Reset
REQ-023 On reset=1 at a clock edge, the block SHALL set state=IDLE, addr=0, length=0, note_out=0, note_valid=0, ram_wren=0, select_q=0 and back_q=0, regardless of the current state.
REQ-024 Reset mid-RECORDING SHALL abort without issuing a write in that cycle.

Verification
REQ-025 Record 3 notes: mode_sel=1; two sel_rise; 3 beat_ticks with note_in=0x1, 0x40, 0x1000; sel_rise -> writes at addr 0,1,2 with that data; length=3; state=0.
REQ-026 Play without loop: loop_en=0, mode_sel=0, sel_rise; 3 beat_ticks with RAM preloaded -> 3 note_valid pulses, each 1 cycle after its tick, note_out=0x1,0x40,0x1000; state=0 afterwards.
REQ-027 Loop playback: loop_en=1; 5 beat_ticks -> read addresses 0,1,2,0,1; back_rise -> note_out=0, state=0.
REQ-028 Full memory: 70 beat_ticks in RECORDING -> exactly 64 writes (addr 0..63), length=64, state=0.
REQ-029 Simultaneous events: beat_tick and sel_rise in the same cycle during RECORDING -> one write occurs and state=0 next cycle; back and select rising together in REC_ARM -> state=0 with length unchanged.
REQ-030 Reset mid-PLAYING (addr=2, pending read) -> next cycle state=0, note_valid=0, length=0.
